// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and helpers for the I2S serialiser family.
//   frame_bits(slot_w) : BCLK periods per stereo frame (two slots).
//   LRCLK_LEFT         : word-select level that marks the left slot.
//   `I2S_CHECK_PARAM   : elaboration-time parameter guard, used inside
//                        module bodies as a labelled generate-if.
`ifndef I2S_PKG_MACROS
`define I2S_PKG_MACROS
`define I2S_CHECK_PARAM(lbl, cond, msg) \
    if (!(cond)) begin : lbl \
        $error(msg); \
    end
`endif

package i2s_pkg;

    localparam logic LRCLK_LEFT = 1'b0;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: bit-clock generator shared by the I2S transmitter and the
// planned receiver. bclk toggles every BCLK_DIV clk cycles, starting low.
//   clk, rst_n : system clock, async active-low reset
//   bclk       : registered bit clock
//   rise, fall : one-cycle strobes, high in the cycle whose closing clk edge
//                makes bclk rise / fall. Consumers update their own
//                registers on that same edge so they move together with bclk.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic rise,
    output logic fall
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             tc;

    assign tc   = (div_q == DIV_W'(BCLK_DIV - 1));
    assign rise = tc && !bclk;
    assign fall = tc && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bclk  <= 1'b0;
        end else if (tc) begin
            div_q <= '0;
            bclk  <= ~bclk;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: parametrised stereo I2S transmitter.
//   i_clk, i_rst_n     : system clock, async active-low reset
//   i_valid / o_ready  : sample-pair handshake into a one-frame holding register
//   i_left, i_right    : DATA_W two's complement samples, sent MSB first
//   o_bclk, o_lrclk    : bit clock and word select (0 = left)
//   o_sdata            : serial data, updated on BCLK falling edges
//   o_frame_start      : one-cycle pulse on each frame load
//   o_underrun         : one-cycle pulse when a frame loads with nothing held
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified output
// (no one-BCLK data delay); default is standard I2S.
module i2s_tx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_bclk,
    output logic              o_lrclk,
    output logic              o_sdata,
    output logic              o_frame_start,
    output logic              o_underrun
);
    localparam int FB  = frame_bits(SLOT_W);
    localparam int K_W = $clog2(FB);

    `I2S_CHECK_PARAM(g_chk_slot, SLOT_W >= DATA_W, "i2s_tx_stereo: SLOT_W must be >= DATA_W")
    `I2S_CHECK_PARAM(g_chk_div, BCLK_DIV >= 1, "i2s_tx_stereo: BCLK_DIV must be >= 1")

    logic bclk, bclk_rise, bclk_fall;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .bclk  (bclk),
        .rise  (bclk_rise),
        .fall  (bclk_fall)
    );

    // The transmitter only acts on falling edges; the rise strobe is for
    // receivers that sample on the opposite edge.
    logic unused_rise;
    assign unused_rise = bclk_rise;

    logic [K_W-1:0]    k_q, k_nxt;
    logic              run_q;          // low in reset so o_ready reads 0 there
    logic              hold_full_q;
    logic [DATA_W-1:0] hold_l_q, hold_r_q;
    logic [FB-1:0]     sr_q;           // frame stream, next bit at MSB
    logic [FB-1:0]     frame_new;
    logic              frame_load, xfer;

    assign k_nxt      = (k_q == K_W'(FB - 1)) ? '0 : k_q + K_W'(1);
    assign frame_load = bclk_fall && (k_nxt == '0);
    assign o_ready    = run_q && !hold_full_q;
    assign xfer       = i_valid && o_ready;
    assign o_bclk     = bclk;

    // Each slot: sample MSB first, zero padded to SLOT_W. Empty register
    // gives a silent frame.
    always_comb begin
        frame_new = '0;
        if (hold_full_q) begin
            frame_new[FB-1 -: DATA_W]     = hold_l_q;
            frame_new[SLOT_W-1 -: DATA_W] = hold_r_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q         <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            k_q           <= K_W'(FB - 1);   // first fall lands on k = 0
            sr_q          <= '0;
            o_lrclk       <= 1'b0;
            o_sdata       <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            o_frame_start <= frame_load;
            o_underrun    <= frame_load && !hold_full_q;

            if (xfer) begin
                hold_l_q <= i_left;
                hold_r_q <= i_right;
            end
            // A transfer can only happen while empty, so on a colliding load
            // the frame underruns and the new pair waits for the next one.
            if (frame_load)
                hold_full_q <= xfer;
            else if (xfer)
                hold_full_q <= 1'b1;

            if (bclk_fall) begin
                k_q     <= k_nxt;
                o_lrclk <= (k_nxt >= K_W'(SLOT_W)) ? ~LRCLK_LEFT : LRCLK_LEFT;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                if (frame_load) begin
                    o_sdata <= frame_new[FB-1];
                    sr_q    <= frame_new << 1;
                end else begin
                    o_sdata <= sr_q[FB-1];
                    sr_q    <= sr_q << 1;
                end
`else
                // One-BCLK delay: at k = 0 the MSB still holds the last bit
                // of the previous frame, emitted as the new frame loads.
                o_sdata <= sr_q[FB-1];
                sr_q    <= frame_load ? frame_new : (sr_q << 1);
`endif
            end
        end
    end

endmodule
